// File: rtl/div64_seq.sv
// Sequential 64-bit unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses a 4-bit-group carry-lookahead adder in a + ~b + 1 form.

module cla64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_ci,
  output logic [63:0] o_s,
  output logic        o_co
);
  logic [63:0] w_g;
  logic [63:0] w_p;
  logic [64:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_pp;
  logic        w_c0;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carries are fully expanded inside each 4-bit group; groups chain on their carry-out.
  always_comb begin
    w_c    = '0;
    w_gg   = '0;
    w_pp   = '0;
    w_c0   = 1'b0;
    w_c[0] = i_ci;
    for (int k = 0; k < 16; k++) begin
      w_gg = w_g[4*k +: 4];
      w_pp = w_p[4*k +: 4];
      w_c0 = w_c[4*k];
      w_c[4*k+1] = w_gg[0] | (w_pp[0] & w_c0);
      w_c[4*k+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c0);
      w_c[4*k+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                 | (w_pp[2] & w_pp[1] & w_pp[0] & w_c0);
      w_c[4*k+4] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                 | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                 | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_c0);
    end
  end

  assign o_s  = w_p ^ w_c[63:0];
  assign o_co = w_c[64];
endmodule

module div64_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        busy,
  output logic        op_done,
  output logic        div_by_zero
);
  localparam int WIDTH = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [5:0]       r_cnt;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_r_next;
  logic             w_ov;
  logic             w_co;
  logic             w_take;

  // R[63] set means the 65-bit shifted remainder already exceeds any 64-bit divisor.
  assign w_s      = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_ov     = r_r[WIDTH-1];
  assign w_take   = w_ov | w_co;
  assign w_r_next = w_take ? w_t : w_s;

  cla64 u_sub (
    .i_a  (w_s),
    .i_b  (~r_d),
    .i_ci (1'b1),
    .o_s  (w_t),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (op_clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (op_start) begin
            r_d         <= divisor;
            r_q         <= dividend;
            r_r         <= '0;
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              r_state     <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              busy        <= 1'b0;
              op_done     <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
              busy    <= 1'b1;
              op_done <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          r_q   <= {r_q[WIDTH-2:0], w_take};
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state   <= ST_DONE;
            quotient  <= {r_q[WIDTH-2:0], w_take};
            remainder <= w_r_next;
            busy      <= 1'b0;
            op_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          op_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div64_seq.sv
// Directed bench for div64_seq: fixed vectors with hand-computed results,
// control corner cases, and a short random sweep checked against q*d+r == a.

module tb_div64_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_start = 1'b0;
  logic        op_clear = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        busy;
  logic        op_done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  div64_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .op_done     (op_done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge with op_start low.
  task automatic do_start(input logic [63:0] a, input logic [63:0] b);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!op_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int          lat;
  logic [63:0] ra, rb;
  logic [127:0] prod;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, op_done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_start(64'd100, 64'd7);
    chk("basic_busy", {63'd0, busy}, 64'd1);
    chk("basic_done0", {63'd0, op_done}, 64'd0);
    wait_done(lat);
    chk("basic_lat", 64'(lat), 64'd64);
    chk("basic_q", quotient, 64'd14);
    chk("basic_r", remainder, 64'd2);
    chk("basic_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", {63'd0, op_done}, 64'd1);
    chk("hold_q", quotient, 64'd14);

    do_start(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_hold_q", quotient, 64'd14);
    wait_done(lat);
    chk("max1_lat", 64'(lat), 64'd64);
    chk("max1_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("max1_r", remainder, 64'd0);

    do_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    wait_done(lat);
    chk("ov_lat", 64'(lat), 64'd64);
    chk("ov_q", quotient, 64'd1);
    chk("ov_r", remainder, 64'h7FFF_FFFF_FFFF_FFFE);

    do_start(64'd12345, 64'd0);
    chk("dbz_done", {63'd0, op_done}, 64'd1);
    chk("dbz_busy", {63'd0, busy}, 64'd0);
    chk("dbz_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dbz_r", remainder, 64'd12345);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);

    do_start(64'd2432902008176640000, 64'd10);
    chk("fact_dbz_clr", {63'd0, div_by_zero}, 64'd0);
    wait_done(lat);
    chk("fact_lat", 64'(lat), 64'd64);
    chk("fact_q", quotient, 64'd243290200817664000);
    chk("fact_r", remainder, 64'd0);
    chk("fact_dbz", {63'd0, div_by_zero}, 64'd0);

    // Start pulse during EXEC must be ignored, and operand changes must not leak in.
    do_start(64'd1000, 64'd3);
    dividend = 64'd5;
    divisor  = 64'd1;
    lat = 0;
    while (!op_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      op_start = (lat == 30);
    end
    op_start = 1'b0;
    chk("ign_lat", 64'(lat), 64'd64);
    chk("ign_q", quotient, 64'd333);
    chk("ign_r", remainder, 64'd1);

    do_start(64'd7, 64'd0);
    chk("dbz2_flag", {63'd0, div_by_zero}, 64'd1);
    op_clear = 1'b1;
    op_start = 1'b1;
    dividend = 64'd9;
    divisor  = 64'd2;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_done", {63'd0, op_done}, 64'd0);
    chk("clr_q", quotient, 64'd0);
    chk("clr_r", remainder, 64'd0);
    chk("clr_dbz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    chk("clr_idle", {62'd0, busy, op_done}, 64'd0);

    do_start(64'd77, 64'd5);
    wait_done(lat);
    chk("idle_q", quotient, 64'd15);
    chk("idle_r", remainder, 64'd2);

    do_start(64'd100, 64'd7);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, op_done}, 64'd0);
    chk("mid_rst_q", quotient, 64'd0);
    chk("mid_rst_r", remainder, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(64'd77, 64'd5);
    wait_done(lat);
    chk("post_rst_lat", 64'(lat), 64'd64);
    chk("post_rst_q", quotient, 64'd15);
    chk("post_rst_r", remainder, 64'd2);

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      case (i % 3)
        0: rb = 64'($urandom_range(255, 1));
        1: rb = {1'b1, 31'($urandom), 32'($urandom)};
        default: rb = {$urandom, $urandom} | 64'd1;
      endcase
      do_start(ra, rb);
      wait_done(lat);
      prod = {64'd0, quotient} * {64'd0, rb} + {64'd0, remainder};
      chk("rand_lat", 64'(lat), 64'd64);
      chk("rand_inv", {63'd0, (prod == {64'd0, ra})}, 64'd1);
      chk("rand_rlt", {63'd0, (remainder < rb)}, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
